bt656_stream_gen: RTL and testbench
===================================

Name: bt656_stream_gen

Overview:
- Synthesizable BT.656 source that drives the source side of the BT.656 stream bundle (DATA/HREF/HSYNC/VSYNC) with embedded EAV/SAV timing codes.
- Produces an interlaced two-field frame carrying a selectable test pattern, without an external decoder.
- Used for loopback of the BT.656 capture path on the board, and as the stimulus source in capture-path simulations.
- The top level drives LLC from the same clock as clk_i. This block never gates or forwards the clock.

Parameters:
- DW, 8, data width; only 8 is supported.
- H_ACTIVE, 720, active pixels per line; the line carries 2*H_ACTIVE active bytes, in Cb Y Cr Y order.
- H_BLANK, 268, blanking bytes between the end of EAV and the start of SAV; must be even.
- V_ACTIVE, 244, active lines per field.
- V_BLANK, 19, vertical-blanking lines per field, placed at the start of each field.

Ports:
- clk_i  in  1  pixel-byte clock, equal to LLC.
- rst_i  in  1  asynchronous, active-high reset.
- en_i  in  1  run request.
- pattern_i  in  2  test pattern: 0 = black, 1 = horizontal ramp, 2 = vertical ramp, 3 = same as 0.
- data_o  out  DW  BT.656 byte stream.
- href_o  out  1  high on active bytes of active lines.
- hsync_o  out  1  high from the first EAV byte through the last blanking byte.
- vsync_o  out  1  high on all bytes of vertical-blanking lines.
- field_o  out  1  current F bit.
- frame_start_o  out  1  one-cycle pulse coincident with the first EAV byte of field 0.

Behaviour:
- Reset state: all outputs 0 and the FSM in IDLE.
- FSM states: IDLE and RUN.
  - IDLE: data_o = 0x00, all strobes 0.
  - IDLE -> RUN when en_i = 1 is sampled in IDLE. The first EAV byte (0xFF) appears on data_o exactly 2 cycles after en_i is first sampled high.
  - RUN -> IDLE only at the frame boundary: en_i is sampled on the last byte of the last line of field 1. If en_i = 0 there, the next cycle is IDLE; otherwise field 0, line 0 follows back-to-back.
  - Deasserting en_i mid-frame has no effect until the frame boundary.
- Counters:
  - byte_cnt runs 0..LINE_BYTES-1, where LINE_BYTES = 8 + H_BLANK + 2*H_ACTIVE.
  - line_cnt runs 0..V_BLANK+V_ACTIVE-1.
  - field toggles when line_cnt wraps; a frame is 2 fields.
  - All counters wrap to 0 with no gap cycles.
- Line layout, by byte_cnt:
  - 0..3: EAV = FF 00 00 XY.
  - 4..3+H_BLANK: alternating 0x80, 0x10.
  - next 4 bytes: SAV = FF 00 00 XY.
  - remaining 2*H_ACTIVE bytes: active video.
- XY byte: bits are 1, F, V, H, P3, P2, P1, P0.
  - P3 = V^H, P2 = F^H, P1 = F^V, P0 = F^V^H.
  - H = 1 for EAV, 0 for SAV.
  - V = 1 when line_cnt < V_BLANK.
  - Valid values: 0x80, 0x9D, 0xAB, 0xB6, 0xC7, 0xDA, 0xEC, 0xF1.
- Active bytes on V-blank lines carry 0x80/0x10 alternating, regardless of pattern.
- Patterns on active lines:
  - Cb and Cr are always 0x80.
  - Y for pattern 0 = 0x10.
  - Y for pattern 1 = 0x10 + (pixel_idx mod 220), where pixel_idx is the active byte index / 2.
  - Y for pattern 2 = 0x10 + ((line_cnt - V_BLANK) mod 220).
  - Generated video must never equal 0x00 or 0xFF.
- pattern_i is registered on the first byte of each frame and held for the whole frame.
- Strobes are registered and change on the same cycle as the data_o byte they describe.
- field_o changes on the first EAV byte of a field.

Test Plan:
- Parameters for all scenarios: H_ACTIVE=4, H_BLANK=4, V_ACTIVE=2, V_BLANK=1. This gives LINE_BYTES = 20 and a frame of 120 cycles.
1. Reset asserted mid-line -> all outputs 0 on the same cycle (asynchronous). After release with en_i = 0, data_o stays 0x00 for 50 cycles.
2. en_i = 1, pattern 0 -> first line is FF 00 00 B6 80 10 80 10 FF 00 00 AB 80 10 80 10 80 10 80 10; vsync_o high for all 20 bytes; frame_start_o high on the first byte only.
3. Pattern 1, field 0 active line -> FF 00 00 9D ... FF 00 00 80 80 10 80 11 80 12 80 13; href_o high for exactly the final 8 bytes.
4. Field 1 -> XY bytes are F1/EC on the blank line and DA/C7 on active lines; field_o = 1 for lines 3..5; frame period is exactly 120 cycles.
5. Pattern 2 plus pattern_i changed mid-frame -> Y = 0x10 on active line 0 and 0x11 on line 1; the new pattern is applied only from the next frame_start_o.
6. en_i dropped at cycle 30 -> the frame completes all 120 bytes, then data_o = 0x00 and all strobes 0 from the next cycle; re-asserting en_i restarts with 0xFF after 2 cycles.

Source files
------------

// File: rtl/bt656_stream_gen_if.sv
// BT.656 source-side stream bundle: run/pattern controls in, byte stream and strobes out.
interface bt656_stream_gen_if #(
  parameter int unsigned DW = 8
) ();
  logic          en_i;
  logic [1:0]    pattern_i;
  logic [DW-1:0] data_o;
  logic          href_o;
  logic          hsync_o;
  logic          vsync_o;
  logic          field_o;
  logic          frame_start_o;

  modport master (
    input  en_i, pattern_i,
    output data_o, href_o, hsync_o, vsync_o, field_o, frame_start_o
  );

  modport slave (
    output en_i, pattern_i,
    input  data_o, href_o, hsync_o, vsync_o, field_o, frame_start_o
  );
endinterface

// File: rtl/bt656_stream_gen.sv
// BT.656 test-pattern source: interlaced two-field frames with embedded EAV/SAV codes.
// Counters feed a generated-byte stage, then an output stage, giving a 2-cycle start latency.
module bt656_stream_gen #(
  parameter int unsigned DW       = 8,
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_BLANK  = 268,
  parameter int unsigned V_ACTIVE = 244,
  parameter int unsigned V_BLANK  = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  bt656_stream_gen_if.master bus
);
  localparam int unsigned LINE_BYTES = 8 + H_BLANK + 2 * H_ACTIVE;
  localparam int unsigned LINES      = V_BLANK + V_ACTIVE;
  localparam int unsigned SAV_START  = 4 + H_BLANK;
  localparam int unsigned ACT_START  = 8 + H_BLANK;
  localparam int unsigned BW         = $clog2(LINE_BYTES + 1);
  localparam int unsigned LW         = $clog2(LINES + 1);

  typedef enum logic {IDLE, RUN} state_e;

  state_e        state_q;
  logic [BW-1:0] byte_q;
  logic [LW-1:0] line_q;
  logic          field_q;
  logic [1:0]    pat_q;
  logic [7:0]    pix_q;
  logic [7:0]    lin_q;

  logic [7:0]    s1_data_d, s1_data_q;
  logic          s1_href_d, s1_href_q;
  logic          s1_hsync_d, s1_hsync_q;
  logic          s1_vsync_d, s1_vsync_q;
  logic          s1_field_d, s1_field_q;
  logic          s1_fs_d, s1_fs_q;

  logic [7:0]    data_q;
  logic          href_q, hsync_q, vsync_q, field_q_o, fs_q;

  logic          v_blank;
  logic          last_byte;
  logic          last_line;
  logic          frame_first;
  logic [BW-1:0] sav_off;
  logic [7:0]    y_val;

  function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  assign v_blank     = line_q < LW'(V_BLANK);
  assign last_byte   = byte_q == BW'(LINE_BYTES - 1);
  assign last_line   = line_q == LW'(LINES - 1);
  assign frame_first = (byte_q == '0) && (line_q == '0) && !field_q;

  // Byte and strobes for the current counter position
  always_comb begin
    s1_data_d  = 8'h00;
    s1_href_d  = 1'b0;
    s1_hsync_d = 1'b0;
    s1_vsync_d = 1'b0;
    s1_field_d = 1'b0;
    s1_fs_d    = 1'b0;
    sav_off    = byte_q - BW'(SAV_START);
    case (pat_q)
      2'd1:    y_val = 8'h10 + pix_q;
      2'd2:    y_val = 8'h10 + lin_q;
      default: y_val = 8'h10;
    endcase
    if (state_q == RUN) begin
      s1_hsync_d = byte_q < BW'(SAV_START);
      s1_vsync_d = v_blank;
      s1_field_d = field_q;
      s1_fs_d    = frame_first;
      s1_href_d  = !v_blank && (byte_q >= BW'(ACT_START));
      if (byte_q < BW'(4)) begin
        case (byte_q[1:0])
          2'd0:    s1_data_d = 8'hFF;
          2'd3:    s1_data_d = xy(field_q, v_blank, 1'b1);
          default: s1_data_d = 8'h00;
        endcase
      end else if (byte_q < BW'(SAV_START)) begin
        s1_data_d = byte_q[0] ? 8'h10 : 8'h80;
      end else if (byte_q < BW'(ACT_START)) begin
        case (sav_off[1:0])
          2'd0:    s1_data_d = 8'hFF;
          2'd3:    s1_data_d = xy(field_q, v_blank, 1'b0);
          default: s1_data_d = 8'h00;
        endcase
      end else if (!byte_q[0] || v_blank) begin
        s1_data_d = byte_q[0] ? 8'h10 : 8'h80;
      end else begin
        s1_data_d = y_val;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      byte_q     <= '0;
      line_q     <= '0;
      field_q    <= 1'b0;
      pat_q      <= 2'd0;
      pix_q      <= 8'd0;
      lin_q      <= 8'd0;
      s1_data_q  <= 8'h00;
      s1_href_q  <= 1'b0;
      s1_hsync_q <= 1'b0;
      s1_vsync_q <= 1'b0;
      s1_field_q <= 1'b0;
      s1_fs_q    <= 1'b0;
      data_q     <= 8'h00;
      href_q     <= 1'b0;
      hsync_q    <= 1'b0;
      vsync_q    <= 1'b0;
      field_q_o  <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      s1_data_q  <= s1_data_d;
      s1_href_q  <= s1_href_d;
      s1_hsync_q <= s1_hsync_d;
      s1_vsync_q <= s1_vsync_d;
      s1_field_q <= s1_field_d;
      s1_fs_q    <= s1_fs_d;
      data_q     <= s1_data_q;
      href_q     <= s1_href_q;
      hsync_q    <= s1_hsync_q;
      vsync_q    <= s1_vsync_q;
      field_q_o  <= s1_field_q;
      fs_q       <= s1_fs_q;
      case (state_q)
        IDLE: begin
          if (bus.en_i) state_q <= RUN;
        end
        RUN: begin
          if (frame_first) pat_q <= bus.pattern_i;
          if (last_byte) begin
            byte_q <= '0;
            pix_q  <= 8'd0;
            if (last_line) begin
              line_q  <= '0;
              lin_q   <= 8'd0;
              field_q <= ~field_q;
              // Run request is only honoured at the frame boundary
              if (field_q && !bus.en_i) state_q <= IDLE;
            end else begin
              line_q <= line_q + LW'(1);
              if (!v_blank) lin_q <= (lin_q == 8'd219) ? 8'd0 : lin_q + 8'd1;
            end
          end else begin
            byte_q <= byte_q + BW'(1);
            if ((byte_q >= BW'(ACT_START)) && byte_q[0])
              pix_q <= (pix_q == 8'd219) ? 8'd0 : pix_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_o        = DW'(data_q);
  assign bus.href_o        = href_q;
  assign bus.hsync_o       = hsync_q;
  assign bus.vsync_o       = vsync_q;
  assign bus.field_o       = field_q_o;
  assign bus.frame_start_o = fs_q;
endmodule

// File: tb/tb_bt656_stream_gen.sv
// Scoreboard bench for bt656_stream_gen with a small 3-line-per-field geometry.
module tb_bt656_stream_gen;
  localparam int HA = 4;
  localparam int HB = 4;
  localparam int VA = 2;
  localparam int VB = 1;
  localparam int LB = 8 + HB + 2 * HA;
  localparam int FLD = (VA + VB) * LB;
  localparam int FB = 2 * FLD;

  typedef struct packed {
    logic [7:0] d;
    logic href;
    logic hsync;
    logic vsync;
    logic field;
    logic fs;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bt656_stream_gen_if #(.DW(8)) bus ();

  bt656_stream_gen #(
    .DW(8), .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus(bus)
  );

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  int pop_idx = 0;
  int cyc = 0;
  int last_fs = -1;
  int idle_run = 0;

  logic [7:0] xy_tbl [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};
  logic [7:0] tbl_p0_l0 [20] = '{8'hFF, 8'h00, 8'h00, 8'hB6, 8'h80, 8'h10, 8'h80, 8'h10,
                                 8'hFF, 8'h00, 8'h00, 8'hAB, 8'h80, 8'h10, 8'h80, 8'h10,
                                 8'h80, 8'h10, 8'h80, 8'h10};
  logic [7:0] tbl_p1_l1 [20] = '{8'hFF, 8'h00, 8'h00, 8'h9D, 8'h80, 8'h10, 8'h80, 8'h10,
                                 8'hFF, 8'h00, 8'h00, 8'h80, 8'h80, 8'h11 - 8'h01, 8'h80, 8'h11,
                                 8'h80, 8'h12, 8'h80, 8'h13};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t sample();
    return {bus.data_o, bus.href_o, bus.hsync_o, bus.vsync_o, bus.field_o, bus.frame_start_o};
  endfunction

  // Reference for byte j of a frame, written from the line layout
  function automatic exp_t model(input int j, input int pat);
    exp_t r;
    int f, ln, b, a;
    logic v;
    f  = j / FLD;
    ln = (j % FLD) / LB;
    b  = j % LB;
    v  = ln < VB;
    r = '0;
    r.field = f[0];
    r.vsync = v;
    r.hsync = b < 4 + HB;
    r.href  = !v && (b >= 8 + HB);
    r.fs    = j == 0;
    if (b < 4 || (b >= 4 + HB && b < 8 + HB)) begin
      a = (b < 4) ? b : b - (4 + HB);
      case (a)
        0: r.d = 8'hFF;
        3: r.d = xy_tbl[{f[0], v, (b < 4) ? 1'b1 : 1'b0}];
        default: r.d = 8'h00;
      endcase
    end else if (b < 4 + HB) begin
      r.d = ((b - 4) % 2 == 0) ? 8'h80 : 8'h10;
    end else begin
      a = b - (8 + HB);
      if (a % 2 == 0) r.d = 8'h80;
      else if (v) r.d = 8'h10;
      else if (pat == 1) r.d = 8'(16 + (a / 2) % 220);
      else if (pat == 2) r.d = 8'(16 + (ln - VB) % 220);
      else r.d = 8'h10;
    end
    return r;
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back('0);
  endtask

  task automatic push_frame(input int pat, input int nbytes, input int tbl_sel);
    exp_t r;
    for (int j = 0; j < nbytes; j++) begin
      r = model(j, pat);
      if (tbl_sel == 1 && j < LB) r.d = tbl_p0_l0[j];
      if (tbl_sel == 2 && j >= LB && j < 2 * LB) r.d = tbl_p1_l1[j - LB];
      q.push_back(r);
    end
  endtask

  // Monitor: pop one expectation per cycle whenever the scoreboard holds one
  always @(negedge clk) begin
    exp_t e, a;
    cyc++;
    a = sample();
    if (q.size() > 0) begin
      e = q.pop_front();
      check($sformatf("stream[%0d]", pop_idx), 32'(a), 32'(e));
      pop_idx++;
    end
    if (rst || (a == '0)) idle_run++;
    else idle_run = 0;
    if (idle_run >= 3) last_fs = -1;
    if (a.fs) begin
      if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FB));
      last_fs = cyc;
    end
  end

  initial begin
    rst = 1'b1;
    bus.en_i = 1'b0;
    bus.pattern_i = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", 32'(sample()), 32'd0);
    rst = 1'b0;
    push_idle(50);
    repeat (50) @(posedge clk);
    #1;

    // Four back-to-back frames with mid-frame pattern changes, en dropped in the last
    bus.en_i = 1'b1;
    push_idle(3);
    push_frame(0, FB, 1);
    push_frame(1, FB, 2);
    push_frame(2, FB, 0);
    push_frame(0, FB, 0);
    push_idle(10);
    for (int i = 1; i <= 3 + 4 * FB + 10; i++) begin
      @(posedge clk);
      #1;
      if (i == 60) bus.pattern_i = 2'd1;
      if (i == 180) bus.pattern_i = 2'd2;
      if (i == 300) bus.pattern_i = 2'd0;
      if (i == 3 * FB + 32) bus.en_i = 1'b0;
    end

    // Restart, then reset asynchronously mid-line
    bus.en_i = 1'b1;
    push_idle(3);
    push_frame(0, 30, 0);
    repeat (33) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset", 32'(sample()), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.en_i = 1'b0;
    push_idle(50);
    repeat (50) @(posedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
